lsu: RTL

Load/store unit for the RV32 core's memory stage, directly downstream of the execute-stage ALU. It takes the ALU result as the effective address, plus store data and access type, and performs one data-memory transaction at a time over a valid/ready bus. It returns sign- or zero-extended load data to writeback, and flags misaligned accesses without touching memory.

---
 rtl/lsu.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/lsu.sv
// RV32 load/store unit: one data-memory transaction at a time over a valid/ready bus,
// with lane steering for stores, load extension for writeback, and misalignment traps.
module lsu #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic            req_we,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  input  logic [4:0]      req_rd,
  output logic            mem_valid,
  input  logic            mem_ready,
  output logic [XLEN-1:0] mem_addr,
  output logic            mem_we,
  output logic [3:0]      mem_be,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            exc_valid,
  output logic [XLEN-1:0] exc_addr,
  output logic            exc_store
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, RESP, EXC} state_t;

  state_t     state;
  logic       lat_we;
  logic [1:0] lat_size;
  logic [1:0] lat_lane;
  logic       lat_unsigned;
  logic [4:0] lat_rd;

  logic            misaligned_c;
  logic [3:0]      be_c;
  logic [XLEN-1:0] wdata_c;
  logic [XLEN-1:0] shifted_c;
  logic [XLEN-1:0] load_data_c;

  // Request decode: alignment check, byte enables and lane-replicated store data
  always_comb begin
    misaligned_c = 1'b0;
    be_c         = 4'b1111;
    wdata_c      = req_wdata;
    case (req_size)
      2'd0: begin
        be_c    = 4'b0001 << req_addr[1:0];
        wdata_c = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        misaligned_c = req_addr[0];
        be_c         = 4'b0011 << req_addr[1:0];
        wdata_c      = {2{req_wdata[15:0]}};
      end
      2'd2: misaligned_c = (req_addr[1:0] != 2'b00);
      default: misaligned_c = 1'b1;
    endcase
    if (!req_we) wdata_c = '0;
  end

  // Load lane select and extension; halves are aligned so the lane shift covers both cases
  always_comb begin
    shifted_c   = mem_rdata >> {lat_lane, 3'b000};
    load_data_c = mem_rdata;
    case (lat_size)
      2'd0: load_data_c = lat_unsigned ? {24'd0, shifted_c[7:0]}
                                       : {{24{shifted_c[7]}}, shifted_c[7:0]};
      2'd1: load_data_c = lat_unsigned ? {16'd0, shifted_c[15:0]}
                                       : {{16{shifted_c[15]}}, shifted_c[15:0]};
      default: load_data_c = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      req_ready    <= 1'b1;
      mem_valid    <= 1'b0;
      mem_addr     <= '0;
      mem_we       <= 1'b0;
      mem_be       <= 4'b0000;
      mem_wdata    <= '0;
      wb_valid     <= 1'b0;
      wb_rd        <= 5'd0;
      wb_data      <= '0;
      exc_valid    <= 1'b0;
      exc_addr     <= '0;
      exc_store    <= 1'b0;
      lat_we       <= 1'b0;
      lat_size     <= 2'd0;
      lat_lane     <= 2'd0;
      lat_unsigned <= 1'b0;
      lat_rd       <= 5'd0;
    end else begin
      wb_valid  <= 1'b0;
      exc_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready    <= 1'b0;
            lat_we       <= req_we;
            lat_size     <= req_size;
            lat_lane     <= req_addr[1:0];
            lat_unsigned <= req_unsigned;
            lat_rd       <= req_rd;
            if (misaligned_c) begin
              state     <= EXC;
              exc_valid <= 1'b1;
              exc_addr  <= req_addr;
              exc_store <= req_we;
            end else begin
              state     <= REQ;
              mem_valid <= 1'b1;
              mem_addr  <= {req_addr[XLEN-1:2], 2'b00};
              mem_we    <= req_we;
              mem_be    <= be_c;
              mem_wdata <= wdata_c;
            end
          end
        end
        REQ: begin
          if (mem_ready) begin
            mem_valid <= 1'b0;
            mem_we    <= 1'b0;
            if (lat_we) begin
              state     <= IDLE;
              req_ready <= 1'b1;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            state    <= RESP;
            wb_valid <= 1'b1;
            wb_rd    <= lat_rd;
            wb_data  <= load_data_c;
          end
        end
        RESP: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        EXC: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
